// File: rtl/info_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : info_scan_controller
// Description : Steps through instruction memory, register file and data
//               memory addresses. Buttons and a timed auto-scan move the
//               address. After each move the controller waits one settle cycle
//               and then captures the selector word for display.
// Revision    : 1.0 - initial release
// ============================================================================
module info_scan_controller #(
    parameter int SCAN_PERIOD = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        nextButton,
    input  logic        prevButton,
    input  logic        modeButton,
    input  logic        autoScan,
    input  logic [31:0] word,
    output logic [1:0]  select,
    output logic [9:0]  derreference,
    output logic [31:0] displayWord,
    output logic        wordValid
);

    localparam int                 c_CNT_W    = $clog2(SCAN_PERIOD);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCAN_PERIOD - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_LATCH  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         r_sel;
    logic [9:0]         r_ref;
    logic [31:0]        r_disp;
    logic               r_valid;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_next_d;
    logic               r_prev_d;
    logic               r_mode_d;

    logic [1:0]         w_state_nxt;
    logic [1:0]         w_sel_nxt;
    logic [9:0]         w_ref_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [9:0]         w_limit;
    logic               w_next_edge;
    logic               w_prev_edge;
    logic               w_mode_edge;

    assign w_next_edge = nextButton & ~r_next_d;
    assign w_prev_edge = prevButton & ~r_prev_d;
    assign w_mode_edge = modeButton & ~r_mode_d;

    // Highest legal address of the currently selected information space
    always_comb begin
        case (r_sel)
            2'd1:    w_limit = 10'd31;
            2'd2:    w_limit = 10'd1023;
            default: w_limit = 10'd255;
        endcase
    end

    // Next-state, address and auto-scan counter decisions; only IDLE accepts commands
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ref_nxt   = r_ref;
        w_cnt_nxt   = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_mode_edge) begin
                    // Mode dominates every other command and restarts the address
                    w_sel_nxt   = (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
                    w_ref_nxt   = '0;
                    w_state_nxt = c_ST_SETTLE;
                end else if (w_next_edge && !w_prev_edge) begin
                    w_ref_nxt   = (r_ref == w_limit) ? 10'd0 : r_ref + 10'd1;
                    w_state_nxt = c_ST_SETTLE;
                end else if (w_prev_edge && !w_next_edge) begin
                    w_ref_nxt   = (r_ref == 10'd0) ? w_limit : r_ref - 10'd1;
                    w_state_nxt = c_ST_SETTLE;
                end else if (w_next_edge && w_prev_edge) begin
                    // Contradictory buttons: no move, and any pending auto step is dropped
                    w_cnt_nxt = '0;
                end else if (autoScan) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_ref_nxt   = (r_ref == w_limit) ? 10'd0 : r_ref + 10'd1;
                        w_state_nxt = c_ST_SETTLE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
            end
            c_ST_SETTLE: w_state_nxt = c_ST_LATCH;
            c_ST_LATCH:  w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State, address, capture and edge-history registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_SETTLE;
            r_sel    <= 2'd0;
            r_ref    <= 10'd0;
            r_disp   <= 32'd0;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
            r_next_d <= 1'b0;
            r_prev_d <= 1'b0;
            r_mode_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_ref    <= w_ref_nxt;
            r_cnt    <= w_cnt_nxt;
            r_valid  <= (r_state == c_ST_LATCH);
            if (r_state == c_ST_LATCH) begin
                r_disp <= word;
            end
            r_next_d <= nextButton;
            r_prev_d <= prevButton;
            r_mode_d <= modeButton;
        end
    end

    assign select       = r_sel;
    assign derreference = r_ref;
    assign displayWord  = r_disp;
    assign wordValid    = r_valid;

endmodule
`default_nettype wire
